// File: rtl/kmeans_pkg.sv
`default_nettype none
// ============================================================================
// Package     : kmeans_pkg
// Description : Shared width constants for the k-means datapath and the state
//               encoding of the centroid-update sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package kmeans_pkg;

    localparam int CENTROID_NUM     = 8;
    localparam int NUM_CORD         = 7;
    localparam int ACCUM_CORD_WIDTH = 22;
    localparam int CORDINATE_WIDTH  = 13;
    localparam int COUNT_WIDTH      = 10;

    typedef enum logic [2:0] {
        UPD_IDLE     = 3'd0,
        UPD_READ     = 3'd1,
        UPD_LOAD     = 3'd2,
        UPD_DIV_WAIT = 3'd3,
        UPD_WRITE    = 3'd4,
        UPD_DONE     = 3'd5
    } upd_state_t;

endpackage : kmeans_pkg
`default_nettype wire

// File: rtl/centroid_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : centroid_update_ctrl
// Description : Walks centroids 0..CENTROID_NUM-1 after an accumulation pass.
//               For each one it reads accumulator/counter, presents them as
//               registered operands to the external divider, waits for the
//               divider latency and writes the quotient to centroid RAM.
//               Zero-count centroids are skipped (no write) and flagged in
//               empty_mask.
// Ports       : clk, rst_n (async, active low)
//               start / busy / done      - run control
//               acc_rd_idx, acc_data, cnt_data - accumulator bank read
//               div_accum, div_counter, div_result - divider interface
//               mem_we, mem_addr, mem_wdata   - centroid RAM write port
//               empty_mask                   - centroids with count 0
// Revision    : 1.0 - initial release
// ============================================================================
module centroid_update_ctrl #(
    parameter int                 CENTROID_NUM     = kmeans_pkg::CENTROID_NUM,
    parameter int                 ACCUM_CORD_WIDTH = kmeans_pkg::ACCUM_CORD_WIDTH,
    parameter int                 ACCUM_WIDTH      = 7 * kmeans_pkg::ACCUM_CORD_WIDTH,
    parameter int                 CORDINATE_WIDTH  = kmeans_pkg::CORDINATE_WIDTH,
    parameter int                 DATA_WIDTH       = 7 * kmeans_pkg::CORDINATE_WIDTH,
    parameter int                 ADDR_WIDTH       = 8,
    parameter int                 COUNT_WIDTH      = kmeans_pkg::COUNT_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] CENT_BASE_ADDR = '0,
    parameter int                 DIV_LATENCY      = 2,
    localparam int                IDX_W            = $clog2(CENTROID_NUM)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        acc_rd_idx,
    input  logic [ACCUM_WIDTH-1:0]  acc_data,
    input  logic [COUNT_WIDTH-1:0]  cnt_data,
    output logic [ACCUM_WIDTH-1:0]  div_accum,
    output logic [COUNT_WIDTH-1:0]  div_counter,
    input  logic [DATA_WIDTH-1:0]   div_result,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [CENTROID_NUM-1:0] empty_mask
);

    import kmeans_pkg::*;

    localparam int WAIT_W = $clog2(DIV_LATENCY + 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    generate
        if (int'(CENT_BASE_ADDR) + CENTROID_NUM > (2 ** ADDR_WIDTH)) begin : g_addr_range_err
            $error("centroid_update_ctrl: CENT_BASE_ADDR + CENTROID_NUM exceeds address space");
        end
        if (DIV_LATENCY < 1) begin : g_latency_err
            $error("centroid_update_ctrl: DIV_LATENCY must be >= 1");
        end
        if ((ACCUM_WIDTH != 7 * ACCUM_CORD_WIDTH) || (DATA_WIDTH != 7 * CORDINATE_WIDTH)) begin : g_width_err
            $error("centroid_update_ctrl: packed widths must hold exactly 7 coordinates");
        end
    endgenerate

    upd_state_t                r_state;
    upd_state_t                w_next;
    logic [IDX_W-1:0]          r_idx;
    logic [WAIT_W-1:0]         r_wait;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_mem_we;
    logic [ADDR_WIDTH-1:0]     r_mem_addr;
    logic [DATA_WIDTH-1:0]     r_mem_wdata;
    logic [ACCUM_WIDTH-1:0]    r_div_accum;
    logic [COUNT_WIDTH-1:0]    r_div_counter;
    logic [CENTROID_NUM-1:0]   r_empty_mask;
    logic                      w_last;

    assign w_last = (r_idx == IDX_W'(CENTROID_NUM - 1));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            UPD_IDLE:     if (start) w_next = UPD_READ;
            UPD_READ:     w_next = UPD_LOAD;
            UPD_LOAD:     w_next = (cnt_data == '0) ? UPD_WRITE : UPD_DIV_WAIT;
            UPD_DIV_WAIT: if (r_wait == '0) w_next = UPD_WRITE;
            UPD_WRITE:    w_next = w_last ? UPD_DONE : UPD_READ;
            UPD_DONE:     w_next = UPD_IDLE;
            default:      w_next = UPD_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and registered datapath. Status outputs are derived
    // from the next state so they line up with the state they describe
    // while still coming straight from flops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= UPD_IDLE;
            r_idx         <= '0;
            r_wait        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_div_accum   <= '0;
            r_div_counter <= '0;
            r_empty_mask  <= '0;
        end else begin
            r_state  <= w_next;
            r_busy   <= (w_next != UPD_IDLE) && (w_next != UPD_DONE);
            r_done   <= (w_next == UPD_DONE);
            // Only the DIV_WAIT path carries a fresh quotient; entering
            // WRITE straight from LOAD means the count was zero.
            r_mem_we <= (r_state == UPD_DIV_WAIT) && (w_next == UPD_WRITE);

            if (w_next == UPD_WRITE) begin
                r_mem_addr <= CENT_BASE_ADDR + ADDR_WIDTH'(r_idx);
            end

            case (r_state)
                UPD_IDLE: begin
                    if (start) begin
                        r_idx        <= '0;
                        r_empty_mask <= '0;
                    end
                end
                UPD_LOAD: begin
                    r_div_accum   <= acc_data;
                    r_div_counter <= cnt_data;
                    if (cnt_data == '0) begin
                        r_empty_mask[r_idx] <= 1'b1;
                    end else begin
                        r_wait <= WAIT_W'(DIV_LATENCY - 1);
                    end
                end
                UPD_DIV_WAIT: begin
                    if (r_wait == '0) begin
                        r_mem_wdata <= div_result;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                UPD_WRITE: begin
                    if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign acc_rd_idx  = r_idx;
    assign div_accum   = r_div_accum;
    assign div_counter = r_div_counter;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign empty_mask  = r_empty_mask;

endmodule : centroid_update_ctrl
`default_nettype wire

// File: tb/tb_centroid_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_centroid_update_ctrl
// Description : Self-checking bench. Two instances run side by side: default
//               parameters and (CENT_BASE_ADDR=0xF0, DIV_LATENCY=4). A
//               behavioural accumulator bank and a latency-aware divider
//               model feed both; a scoreboard of expected RAM writes and
//               run lengths is filled at start and drained by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_centroid_update_ctrl;

    localparam int NC = 8;
    localparam int AW = 154;
    localparam int DW = 91;
    localparam int CW = 10;

    typedef struct {
        logic [7:0]    a;
        logic [DW-1:0] d;
        logic [AW-1:0] acc;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           start;
    logic           busy       [2];
    logic           done       [2];
    logic           mem_we     [2];
    logic [2:0]     acc_rd_idx [2];
    logic [AW-1:0]  acc_data   [2];
    logic [AW-1:0]  div_accum  [2];
    logic [CW-1:0]  cnt_data   [2];
    logic [CW-1:0]  div_counter[2];
    logic [DW-1:0]  div_result [2];
    logic [DW-1:0]  mem_wdata  [2];
    logic [7:0]     mem_addr   [2];
    logic [7:0]     empty_mask [2];

    centroid_update_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[0]), .done(done[0]),
        .acc_rd_idx(acc_rd_idx[0]), .acc_data(acc_data[0]), .cnt_data(cnt_data[0]),
        .div_accum(div_accum[0]), .div_counter(div_counter[0]), .div_result(div_result[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .empty_mask(empty_mask[0])
    );

    centroid_update_ctrl #(.CENT_BASE_ADDR(8'hF0), .DIV_LATENCY(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[1]), .done(done[1]),
        .acc_rd_idx(acc_rd_idx[1]), .acc_data(acc_data[1]), .cnt_data(cnt_data[1]),
        .div_accum(div_accum[1]), .div_counter(div_counter[1]), .div_result(div_result[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .empty_mask(empty_mask[1])
    );

    int unsigned lat  [2] = '{2, 4};
    int unsigned base [2] = '{0, 240};

    // Accumulator bank contents for the current run
    logic [21:0]   bank_acc [NC][7];
    logic [CW-1:0] bank_cnt [NC];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard state
    wr_t q0[$];
    wr_t q1[$];
    bit  active   [2];
    int  exp_len  [2];
    logic [7:0] exp_mask [2];
    int  start_cyc;
    int  ndone    [2];
    int  stab     [2];
    logic [AW-1:0] prev_acc [2];
    logic [CW-1:0] prev_cnt [2];

    task automatic chk(input string nm, input int u, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s u%0d: got %0h expected %0h", nm, u, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] pack_acc(input int i);
        logic [AW-1:0] v = '0;
        for (int k = 0; k < 7; k++) v[k*22 +: 22] = bank_acc[i][k];
        return v;
    endfunction

    // Divider reference: each coordinate is the truncated integer mean
    function automatic logic [DW-1:0] quot(input logic [AW-1:0] a, input logic [CW-1:0] c);
        logic [DW-1:0] r = '0;
        if (c != 0) begin
            for (int k = 0; k < 7; k++) r[k*13 +: 13] = 13'(a[k*22 +: 22] / c);
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator bank: one cycle of read latency
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            acc_data[u] <= pack_acc(int'(acc_rd_idx[u]));
            cnt_data[u] <= bank_cnt[acc_rd_idx[u]];
        end
    end

    // Monitor + divider model, evaluated away from the active edge
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            // Divider: result only valid once operands held for the latency
            if (div_accum[u] !== prev_acc[u] || div_counter[u] !== prev_cnt[u]) stab[u] = 0;
            else if (stab[u] < 1000) stab[u] = stab[u] + 1;
            prev_acc[u] = div_accum[u];
            prev_cnt[u] = div_counter[u];
            div_result[u] = (stab[u] >= int'(lat[u]) - 1) ? quot(div_accum[u], div_counter[u])
                                                           : ~quot(div_accum[u], div_counter[u]);
            if (rst_n) begin
                if (mem_we[u]) begin
                    wr_t e;
                    bit  have;
                    have = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    chk("write_expected", u, {159'd0, have}, 160'd1);
                    if (have) begin
                        e = (u == 0) ? q0.pop_front() : q1.pop_front();
                        chk("mem_addr", u, {152'd0, mem_addr[u]}, {152'd0, e.a});
                        chk("mem_wdata", u, {69'd0, mem_wdata[u]}, {69'd0, e.d});
                        chk("div_accum", u, {6'd0, div_accum[u]}, {6'd0, e.acc});
                        chk("operand_stable", u, {159'd0, (stab[u] >= int'(lat[u]))}, 160'd1);
                    end
                end
                if (done[u]) begin
                    chk("done_expected", u, {159'd0, active[u]}, 160'd1);
                    if (active[u]) begin
                        chk("done_cycle", u, 160'(cyc - start_cyc + 1), 160'(exp_len[u] + 1));
                        chk("empty_mask", u, {152'd0, empty_mask[u]}, {152'd0, exp_mask[u]});
                        chk("writes_left", u, 160'((u == 0) ? q0.size() : q1.size()), 160'd0);
                        chk("busy_at_done", u, {159'd0, busy[u]}, 160'd0);
                        active[u] = 1'b0;
                    end
                    ndone[u]++;
                end
            end
        end
    end

    // Pulse start and record the expected outcome for both instances
    task automatic start_run();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        for (int u = 0; u < 2; u++) begin
            int s = 0;
            exp_mask[u] = '0;
            for (int i = 0; i < NC; i++) begin
                if (bank_cnt[i] == 0) begin
                    exp_mask[u][i] = 1'b1;
                    s += 3;
                end else begin
                    wr_t e;
                    e.a   = 8'(base[u] + i);
                    e.acc = pack_acc(i);
                    e.d   = quot(e.acc, bank_cnt[i]);
                    if (u == 0) q0.push_back(e); else q1.push_back(e);
                    s += 3 + int'(lat[u]);
                end
            end
            exp_len[u] = s;
            active[u]  = 1'b1;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((active[0] || active[1]) && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (active[0] || active[1]) begin
            failures++;
            $display("FAIL run_timeout: active=%0d%0d after %0d cycles, required 00", active[0], active[1], n);
            active[0] = 1'b0;
            active[1] = 1'b0;
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int u = 0; u < 2; u++) begin
            chk({tag, "_busy"}, u, {159'd0, busy[u]}, 160'd0);
            chk({tag, "_mem_we"}, u, {159'd0, mem_we[u]}, 160'd0);
            chk({tag, "_done"}, u, {159'd0, done[u]}, 160'd0);
            chk({tag, "_addr_data"}, u, {61'd0, mem_addr[u], mem_wdata[u]}, 160'd0);
            chk({tag, "_operands"}, u, {div_counter[u], div_accum[u]}, 160'd0);
            chk({tag, "_idx_mask"}, u, {149'd0, acc_rd_idx[u], empty_mask[u]}, 160'd0);
        end
    endtask

    task automatic fill_random(input bit allow_zero);
        for (int i = 0; i < NC; i++) begin
            for (int k = 0; k < 7; k++) bank_acc[i][k] = 22'($urandom_range(0, 22'h3FFFFF));
            if (allow_zero && $urandom_range(0, 3) == 0) bank_cnt[i] = '0;
            else bank_cnt[i] = CW'($urandom_range(1, 1023));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int u = 0; u < 2; u++) begin
            active[u] = 1'b0; ndone[u] = 0; stab[u] = 0;
            prev_acc[u] = '0; prev_cnt[u] = '0; div_result[u] = '0;
        end
        for (int i = 0; i < NC; i++) begin
            for (int k = 0; k < 7; k++) bank_acc[i][k] = 22'd40;
            bank_cnt[i] = 10'd4;
        end
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Uniform data: every coordinate 40/4 = 10
        start_run();
        wait_done();

        // Centroid 3 empty, all others count 1
        fill_random(1'b0);
        for (int i = 0; i < NC; i++) bank_cnt[i] = 10'd1;
        bank_cnt[3] = '0;
        start_run();
        wait_done();

        // Second start during the run must be ignored
        fill_random(1'b1);
        ndone[0] = 0;
        ndone[1] = 0;
        start_run();
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        repeat (60) @(posedge clk);
        for (int u = 0; u < 2; u++) chk("single_done", u, 160'(ndone[u]), 160'd1);

        // Asynchronous reset in DIV_WAIT of centroid 5 (default instance)
        fill_random(1'b0);
        start_run();
        repeat (27) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        q0.delete();
        q1.delete();
        active[0] = 1'b0;
        active[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_run();
        wait_done();

        // Random runs with occasional empty centroids
        for (int r = 0; r < 4; r++) begin
            fill_random(1'b1);
            start_run();
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_centroid_update_ctrl
`default_nettype wire
